synapse_weight_loader: RTL and testbench
========================================

# synapse_weight_loader

Streams 16-bit synaptic weights from an upstream host/FIFO into the synaptic weight memory by acting as the AXI4-Lite write master in front of the weight memory slave. Software programs a start index and word count, pulses `start`, and the loader issues one single-beat AXI4-Lite write per weight, checks each response, and reports completion and error status. It sits between the host weight stream (configuration path) and the weight memory's AXI4-Lite slave port.

## Interface

- `NUM_SYNAPSES`, 72895, number of weight words in the target memory; legal indices 0..NUM_SYNAPSES-1
- `BASE_ADDR`, 32'h0000_0000, byte address of weight index 0 in the slave address map
- `clk` in 1: single clock; all logic rising-edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: one-cycle launch pulse; sampled only in IDLE
- `start_index` in 32: first weight index, sampled with `start`
- `word_count` in 32: number of weights to write, sampled with `start`
- `s_valid` in 1 / `s_ready` out 1 / `s_data` in 16: weight input stream, valid/ready handshake
- `m_axi_awaddr` out 32, `m_axi_awvalid` out 1, `m_axi_awready` in 1: write address channel
- `m_axi_wdata` out 32, `m_axi_wstrb` out 4, `m_axi_wvalid` out 1, `m_axi_wready` in 1: write data channel
- `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1: write response channel
- `busy` out 1: high from accepted `start` until the cycle `done` is asserted
- `done` out 1: one-cycle completion pulse
- `error` out 1: status of last run; valid from `done` until next accepted `start`
- `words_written` out 32: count of OKAY-acknowledged writes in the current/last run

## Operation

- Reset values: all outputs 0 (`s_ready`, all AXI valids/`bready`, `awaddr`, `wdata`, `wstrb`, `busy`, `done`, `error`, `words_written`). Reset mid-run drops the transaction in flight; no recovery.
- States: IDLE, CHECK, FETCH, WRITE, RESP, FINISH.
- IDLE: on `start`, latch `start_index`, `word_count`; clear `error`, `words_written`; `busy`<=1; go CHECK. `start` in any other state ignored.
- CHECK: if `word_count`==0 -> FINISH, no error. If `start_index` >= NUM_SYNAPSES or `word_count` > NUM_SYNAPSES - `start_index` -> `error`<=1, FINISH, no AXI traffic. Else FETCH. Range arithmetic is 33-bit; no wrap.
- FETCH: `s_ready`=1. On `s_valid`&&`s_ready`: `wdata`<={16'h0,`s_data`}, `wstrb`<=4'b0011, `awaddr`<=BASE_ADDR + 4*current index (32-bit, modulo 2^32), assert `awvalid` and `wvalid` together; go WRITE.
- WRITE: each valid held stable until its own ready handshake, then dropped the next edge; the two channels complete independently in any order, including same cycle. When both done -> RESP.
- RESP: `bready`=1. On `bvalid`: bresp==2'b00 -> `words_written`++, index++; if `words_written`+1 == `word_count` -> FINISH else FETCH. bresp!=00 -> `error`<=1, FINISH (remaining words not fetched; stream left untouched).
- FINISH: `done`=1, `busy`<=0 for one cycle; -> IDLE.

## Timing

- `start` to first `s_ready`: 2 cycles (IDLE->CHECK->FETCH).
- Stream handshake cycle N -> `awvalid`/`wvalid` high from N+1.
- `bready` asserted from the cycle after the later of AW/W handshakes; next `s_ready` the cycle after `bvalid` handshake.
- Exactly one outstanding write; no stream word accepted while a write or response is pending.
- `s_ready` never high outside FETCH; `bready` never high outside RESP.
- `done` high exactly one cycle per accepted `start`; `busy` low in that same cycle.

## Test plan

- Basic: start_index=0, word_count=3, stream 16'h0011, 16'h0022, 16'h0033 into the weight memory model -> awaddr 0x0, 0x4, 0x8; wdata 0x00000011/22/33, wstrb 4'b0011; readback matches; `done` once, error=0, words_written=3.
- Slow slave: awready 4 cycles before wready, then wready before awready on next beat, bvalid delayed 5 cycles -> valids stable until handshake, no duplicated or lost beat, words_written=2.
- Range reject: start_index=72894, word_count=2 -> error=1, done 2 cycles after start, zero AW/W transactions, s_ready never asserted.
- Zero count: word_count=0 -> done with error=0, words_written=0, no AXI or stream activity.
- SLVERR mid-run: word_count=4, bresp=2'b10 on second write -> error=1, words_written=1, third stream word not consumed.
- Disturbance: `start` pulsed while busy is ignored; `rst` asserted during WRITE -> next cycle all outputs 0, state IDLE, new run completes normally.

Source files
------------

// File: rtl/synapse_weight_loader.sv
// AXI4-Lite write master that streams 16-bit synaptic weights into the weight memory.
// One single-beat write per weight, response checked before the next word is taken.
module synapse_weight_loader #(
  parameter int unsigned NUM_SYNAPSES = 72895,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] start_index,
  input  logic [31:0] word_count,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] words_written
);

  localparam int unsigned IDX_W = 32;
  localparam int unsigned RNG_W = IDX_W + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]       state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [IDX_W-1:0] cnt, cnt_d;
  logic             s_ready_d;
  logic [31:0]      awaddr_d, wdata_d;
  logic [3:0]       wstrb_d;
  logic             awvalid_d, wvalid_d, bready_d;
  logic             busy_d, done_d, error_d;
  logic [31:0]      words_written_d;

  // Range check is done one bit wider so index + count can never wrap.
  logic [RNG_W-1:0] num_ext, idx_ext, cnt_ext;
  logic             range_bad;
  logic             aw_pend, w_pend;
  logic             last_word;

  assign num_ext   = RNG_W'(NUM_SYNAPSES);
  assign idx_ext   = {1'b0, idx};
  assign cnt_ext   = {1'b0, cnt};
  assign range_bad = (idx_ext >= num_ext) || (cnt_ext > (num_ext - idx_ext));
  assign aw_pend   = m_axi_awvalid && !m_axi_awready;
  assign w_pend    = m_axi_wvalid && !m_axi_wready;
  assign last_word = ((words_written + 32'd1) == cnt);

  // Next-state and registered-output logic.
  always_comb begin
    state_d         = state;
    idx_d           = idx;
    cnt_d           = cnt;
    s_ready_d       = s_ready;
    awaddr_d        = m_axi_awaddr;
    wdata_d         = m_axi_wdata;
    wstrb_d         = m_axi_wstrb;
    awvalid_d       = m_axi_awvalid;
    wvalid_d        = m_axi_wvalid;
    bready_d        = m_axi_bready;
    busy_d          = busy;
    done_d          = 1'b0;
    error_d         = error;
    words_written_d = words_written;

    case (state)
      S_IDLE: begin
        if (start) begin
          idx_d           = start_index;
          cnt_d           = word_count;
          error_d         = 1'b0;
          words_written_d = 32'd0;
          busy_d          = 1'b1;
          state_d         = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cnt == 32'd0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FINISH;
        end else if (range_bad) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FINISH;
        end else begin
          s_ready_d = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        if (s_valid && s_ready) begin
          s_ready_d = 1'b0;
          wdata_d   = {16'h0000, s_data};
          wstrb_d   = 4'b0011;
          awaddr_d  = BASE_ADDR + {idx[IDX_W-3:0], 2'b00};
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        // AW and W retire independently; move on once neither is pending.
        awvalid_d = aw_pend;
        wvalid_d  = w_pend;
        if (!aw_pend && !w_pend) begin
          bready_d = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          if (m_axi_bresp == 2'b00) begin
            words_written_d = words_written + 32'd1;
            idx_d           = idx + 32'd1;
            if (last_word) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_FINISH;
            end else begin
              s_ready_d = 1'b1;
              state_d   = S_FETCH;
            end
          end else begin
            error_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      idx           <= '0;
      cnt           <= '0;
      s_ready       <= 1'b0;
      m_axi_awaddr  <= 32'd0;
      m_axi_wdata   <= 32'd0;
      m_axi_wstrb   <= 4'd0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= 32'd0;
    end else begin
      state         <= state_d;
      idx           <= idx_d;
      cnt           <= cnt_d;
      s_ready       <= s_ready_d;
      m_axi_awaddr  <= awaddr_d;
      m_axi_wdata   <= wdata_d;
      m_axi_wstrb   <= wstrb_d;
      m_axi_awvalid <= awvalid_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_bready  <= bready_d;
      busy          <= busy_d;
      done          <= done_d;
      error         <= error_d;
      words_written <= words_written_d;
    end
  end

endmodule

// File: tb/tb_synapse_weight_loader.sv
// Scoreboard bench: stimulus queues expected writes/completions; a slave+monitor process checks them.
module tb_synapse_weight_loader;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] start_index, word_count;
  logic        s_valid, s_ready;
  logic [15:0] s_data;
  logic [31:0] m_axi_awaddr, m_axi_wdata;
  logic        m_axi_awvalid, m_axi_awready;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic        busy, done, error;
  logic [31:0] words_written;

  always #5 clk = ~clk;

  synapse_weight_loader dut (
    .clk(clk), .rst(rst), .start(start), .start_index(start_index), .word_count(word_count),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .busy(busy), .done(done), .error(error),
    .words_written(words_written)
  );

  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
    logic [1:0]  resp;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
  } wr_t;

  typedef struct {
    logic        err;
    logic [31:0] ww;
    int          aw_n;
    int          s_n;
    int          left;
    int          lat;
  } fin_t;

  // Written by stimulus only (tails); heads are advanced by the monitor only.
  wr_t         exp_mem [0:31];
  fin_t        fin_mem [0:15];
  logic [15:0] str_mem [0:31];
  int exp_tail = 0, fin_tail = 0, str_tail = 0;
  int tmo_req = 0;
  logic end_req = 1'b0;

  // Monitor-owned state.
  int exp_head = 0, fin_head = 0, str_head = 0;
  int checks = 0, failures = 0, done_cnt = 0;
  logic end_ack = 1'b0;
  wr_t  m_cur;
  fin_t m_fin;
  logic m_hs_aw = 1'b0, m_hs_w = 1'b0, m_hs_b = 1'b0, m_hs_s = 1'b0;
  logic m_aw_pend = 1'b0, m_w_pend = 1'b0, m_aw_drop = 1'b0, m_w_drop = 1'b0;
  logic m_aw_got = 1'b0, m_w_got = 1'b0, m_beat = 1'b0;
  logic m_rst_prev = 1'b0, m_done_prev = 1'b0, m_lat_on = 1'b0;
  int m_aw_c = 0, m_w_c = 0, m_b_c = 0, m_run_aw = 0, m_run_s = 0, m_run_sr = 0, m_lat = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // AXI slave, stream source and scoreboard, all advanced on the falling edge.
  initial begin
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    s_valid = 1'b0; s_data = 16'h0;
    forever begin
      @(negedge clk);
      if (m_hs_s) begin str_head++; m_run_s++; end
      if (m_hs_aw) m_axi_awready = 1'b0;
      if (m_hs_w)  m_axi_wready  = 1'b0;
      if (m_hs_b) begin m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; m_beat = 1'b0; end
      m_aw_drop = m_hs_aw; m_w_drop = m_hs_w;
      m_hs_aw = 1'b0; m_hs_w = 1'b0; m_hs_b = 1'b0; m_hs_s = 1'b0;
      if (m_rst_prev) begin
        check("reset_ctrl", 64'({s_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, done,
                                 error, m_axi_wstrb, words_written}), 64'd0);
        check("reset_addr_data", {m_axi_awaddr, m_axi_wdata}, 64'd0);
      end
      if (rst) begin
        m_beat = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        m_aw_pend = 1'b0; m_w_pend = 1'b0; m_aw_drop = 1'b0; m_w_drop = 1'b0;
        m_run_aw = 0; m_run_s = 0; m_run_sr = 0; m_lat_on = 1'b0;
      end else begin
        if (m_aw_pend) check("aw_hold", 64'({m_axi_awvalid, m_axi_awaddr}), 64'({1'b1, m_cur.addr}));
        if (m_w_pend)  check("w_hold", 64'({m_axi_wvalid, m_axi_wdata}), 64'({1'b1, 16'h0, m_cur.data}));
        if (m_aw_drop) check("aw_drop", 64'(m_axi_awvalid), 64'd0);
        if (m_w_drop)  check("w_drop", 64'(m_axi_wvalid), 64'd0);
        if (!m_beat && (m_axi_awvalid || m_axi_wvalid)) begin
          if (exp_head < exp_tail) begin
            m_cur = exp_mem[exp_head];
            exp_head++;
          end else begin
            check("unexpected_write", 64'({m_axi_awvalid, m_axi_wvalid}), 64'd0);
            m_cur = '{m_axi_awaddr, m_axi_wdata[15:0], 2'b00, 0, 0, 0};
          end
          m_beat = 1'b1; m_aw_got = 1'b0; m_w_got = 1'b0;
          m_aw_c = 0; m_w_c = 0; m_b_c = 0; m_run_aw++;
        end
        if (m_beat) begin
          if (m_axi_awvalid && !m_aw_got && !m_axi_awready) begin
            if (m_aw_c >= m_cur.aw_dly) m_axi_awready = 1'b1; else m_aw_c++;
          end
          if (m_axi_wvalid && !m_w_got && !m_axi_wready) begin
            if (m_w_c >= m_cur.w_dly) m_axi_wready = 1'b1; else m_w_c++;
          end
          if (m_aw_got && m_w_got && !m_axi_bvalid) begin
            if (m_b_c >= m_cur.b_dly) begin m_axi_bvalid = 1'b1; m_axi_bresp = m_cur.resp; end
            else m_b_c++;
          end
        end
        if (m_axi_bready) check("bready_after_aw_w", 64'({m_aw_got, m_w_got}), 64'd3);
        s_valid = (str_head < str_tail);
        s_data  = s_valid ? str_mem[str_head] : 16'h0;
        m_hs_aw = m_axi_awvalid && m_axi_awready;
        if (m_hs_aw) begin check("awaddr", 64'(m_axi_awaddr), 64'(m_cur.addr)); m_aw_got = 1'b1; end
        m_hs_w = m_axi_wvalid && m_axi_wready;
        if (m_hs_w) begin
          check("wdata", 64'(m_axi_wdata), 64'({16'h0, m_cur.data}));
          check("wstrb", 64'(m_axi_wstrb), 64'd3);
          m_w_got = 1'b1;
        end
        m_hs_b = m_axi_bvalid && m_axi_bready;
        m_hs_s = s_valid && s_ready;
        if (s_ready) m_run_sr++;
        m_aw_pend = m_axi_awvalid && !m_hs_aw;
        m_w_pend  = m_axi_wvalid && !m_hs_w;
        if (m_lat_on) m_lat++;
        if (start && !busy && !done) begin m_lat_on = 1'b1; m_lat = 0; end
        if (m_done_prev) check("done_pulse_width", 64'(done), 64'd0);
        if (done) begin
          if (fin_head < fin_tail) begin
            m_fin = fin_mem[fin_head];
            fin_head++;
            check("done_error", 64'(error), 64'(m_fin.err));
            check("words_written", 64'(words_written), 64'(m_fin.ww));
            check("busy_at_done", 64'(busy), 64'd0);
            check("aw_beats", 64'(m_run_aw), 64'(m_fin.aw_n));
            check("stream_words", 64'(m_run_s), 64'(m_fin.s_n));
            check("s_ready_cycles", 64'(m_run_sr), 64'(m_fin.s_n));
            check("stream_left", 64'(str_tail - str_head), 64'(m_fin.left));
            if (m_fin.lat >= 0) check("done_latency", 64'(m_lat), 64'(m_fin.lat));
          end else begin
            check("unexpected_done", 64'(done), 64'd0);
          end
          done_cnt++;
          m_run_aw = 0; m_run_s = 0; m_run_sr = 0; m_lat_on = 1'b0;
        end
      end
      if (end_req && !end_ack) begin
        check("writes_left", 64'(exp_tail - exp_head), 64'd0);
        check("runs_left", 64'(fin_tail - fin_head), 64'd0);
        check("timeouts", 64'(tmo_req), 64'd0);
        end_ack = 1'b1;
      end
      m_done_prev = done && !rst;
      m_rst_prev  = rst;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input logic [31:0] addr, input logic [15:0] data, input logic [1:0] resp,
                        input int aw_dly, input int w_dly, input int b_dly);
    exp_mem[exp_tail] = '{addr, data, resp, aw_dly, w_dly, b_dly};
    exp_tail++;
  endtask

  task automatic exp_fin(input logic err, input logic [31:0] ww, input int aw_n, input int s_n,
                         input int left, input int lat);
    fin_mem[fin_tail] = '{err, ww, aw_n, s_n, left, lat};
    fin_tail++;
  endtask

  task automatic push_word(input logic [15:0] d);
    str_mem[str_tail] = d;
    str_tail++;
  endtask

  task automatic launch(input logic [31:0] idx, input logic [31:0] cnt);
    start = 1'b1; start_index = idx; word_count = cnt;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 2000) begin tick(1); n++; end
    if (done_cnt < target) tmo_req++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_index = 32'd0; word_count = 32'd0;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Basic three-word run, with a stray start pulse while busy.
    push_word(16'h0011); push_word(16'h0022); push_word(16'h0033);
    exp_wr(32'h0000_0000, 16'h0011, 2'b00, 0, 0, 0);
    exp_wr(32'h0000_0004, 16'h0022, 2'b00, 0, 0, 0);
    exp_wr(32'h0000_0008, 16'h0033, 2'b00, 0, 0, 0);
    exp_fin(1'b0, 32'd3, 3, 3, 0, -1);
    launch(32'd0, 32'd3);
    tick(3);
    start = 1'b1; start_index = 32'd7; word_count = 32'd2;
    tick(1);
    start = 1'b0;
    wait_done(1);

    // Slow slave: AW before W, then W before AW, late responses.
    push_word(16'hA5A5); push_word(16'h1234);
    exp_wr(32'h0000_0190, 16'hA5A5, 2'b00, 0, 4, 5);
    exp_wr(32'h0000_0194, 16'h1234, 2'b00, 3, 0, 5);
    exp_fin(1'b0, 32'd2, 2, 2, 0, -1);
    launch(32'd100, 32'd2);
    wait_done(2);

    // Range reject at the top of the memory.
    exp_fin(1'b1, 32'd0, 0, 0, 0, 2);
    launch(32'd72894, 32'd2);
    wait_done(3);

    // Zero count.
    exp_fin(1'b0, 32'd0, 0, 0, 0, 2);
    launch(32'd5, 32'd0);
    wait_done(4);

    // SLVERR on the second write leaves words 3 and 4 in the stream.
    push_word(16'h0001); push_word(16'h0002); push_word(16'h0003); push_word(16'h0004);
    exp_wr(32'h0000_0028, 16'h0001, 2'b00, 1, 0, 0);
    exp_wr(32'h0000_002C, 16'h0002, 2'b10, 0, 1, 2);
    exp_fin(1'b1, 32'd1, 2, 2, 2, -1);
    launch(32'd10, 32'd4);
    wait_done(5);

    // Reset during WRITE consumes word 3; the following run takes word 4.
    exp_wr(32'h0000_0040, 16'h0003, 2'b00, 20, 20, 0);
    launch(32'd16, 32'd1);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    exp_wr(32'h0000_0050, 16'h0004, 2'b00, 1, 2, 1);
    exp_fin(1'b0, 32'd1, 1, 1, 0, -1);
    launch(32'd20, 32'd1);
    wait_done(6);

    tick(2);
    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_ack; i++) tick(1);
    if (!end_ack) $display("FAIL end_check: actual=0 expected=1");
    $display("TB_RESULT checks=%0d failures=%0d", checks, end_ack ? failures : failures + 1);
    $finish;
  end

endmodule
